// File: rtl/pipe_hazard_unit.sv
// Scoreboard, forwarding-select and load-use stall unit for the pipelined core.
// Tracks DEPTH in-flight register writes; the youngest matching producer wins.
module pipe_hazard_unit #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int NUM_SRC             = 2,
  parameter int DEPTH               = 3,
  parameter int LOAD_READY          = 1,
  parameter int KILL_STAGES         = 1,
  parameter int HARD_ZERO           = 0,
  parameter int CNT_BITS            = 32,
  localparam int FWD_W              = $clog2(DEPTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   issue_valid,
  input  logic                                   issue_wr,
  input  logic                                   issue_load,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]         issue_dest,
  input  logic [NUM_SRC-1:0]                     src_valid,
  input  logic [NUM_SRC*REG_INDEX_BIT_WIDTH-1:0] src_idx,
  input  logic                                   flush,
  output logic                                   stall,
  output logic [NUM_SRC*FWD_W-1:0]               fwd_sel,
  output logic                                   wb_valid,
  output logic [REG_INDEX_BIT_WIDTH-1:0]         wb_dest,
  output logic [CNT_BITS-1:0]                    stall_count
);

  localparam int RIW = REG_INDEX_BIT_WIDTH;

  logic [DEPTH-1:0]         valid_r;
  logic [DEPTH-1:0]         load_r;
  logic [RIW-1:0]           dest_r [DEPTH];
  logic [CNT_BITS-1:0]      stall_cnt_r;

  logic [NUM_SRC*FWD_W-1:0] fwd_sel_s;
  logic [NUM_SRC-1:0]       req_s;
  logic                     stall_s;
  logic                     entry0_wr_s;

  function automatic logic hz_match(input logic sv, input logic ev,
                                    input logic [RIW-1:0] ed,
                                    input logic [RIW-1:0] si);
    logic zero_excluded;
    zero_excluded = (HARD_ZERO != 0) && (si == {RIW{1'b0}});
    hz_match = sv && ev && (ed == si) && !zero_excluded;
  endfunction

  // Per-port source select; scanning oldest to youngest lets the youngest match win.
  always_comb begin
    fwd_sel_s = {(NUM_SRC*FWD_W){1'b0}};
    req_s     = {NUM_SRC{1'b0}};
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        logic m_s;
        logic early_load_s;
        m_s          = hz_match(src_valid[s], valid_r[i], dest_r[i], src_idx[s*RIW +: RIW]);
        early_load_s = load_r[i] && (i < LOAD_READY);
        fwd_sel_s[s*FWD_W +: FWD_W] = m_s ? (early_load_s ? {FWD_W{1'b0}} : FWD_W'(i + 1))
                                          : fwd_sel_s[s*FWD_W +: FWD_W];
        req_s[s] = m_s ? early_load_s : req_s[s];
      end
    end
  end

  assign stall_s     = issue_valid && !flush && (|req_s);
  assign entry0_wr_s = issue_valid && issue_wr && !stall_s && !flush;

  // Scoreboard shift; flush invalidates the youngest KILL_STAGES entries after the shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= {DEPTH{1'b0}};
      load_r  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        dest_r[i] <= {RIW{1'b0}};
      end
    end else begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        valid_r[i] <= valid_r[i-1] && !(flush && (i < KILL_STAGES));
        load_r[i]  <= load_r[i-1];
        dest_r[i]  <= dest_r[i-1];
      end
      valid_r[0] <= entry0_wr_s;
      load_r[0]  <= entry0_wr_s ? issue_load : 1'b0;
      dest_r[0]  <= entry0_wr_s ? issue_dest : {RIW{1'b0}};
    end
  end

  // Saturating stall-cycle counter for performance readout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_BITS{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_BITS{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall       = stall_s;
  assign fwd_sel     = fwd_sel_s;
  assign wb_valid    = valid_r[DEPTH-1];
  assign wb_dest     = dest_r[DEPTH-1];
  assign stall_count = stall_cnt_r;

endmodule
